// File: rtl/lz77_pkg.sv
// Shared state encoding and width helpers for the LZ77 stream encoder.
package lz77_pkg;

  typedef enum logic [2:0] {
    StFill,
    StMatch,
    StEmit,
    StShift,
    StDone
  } state_e;

  function automatic int unsigned off_w(input int unsigned search_len);
    return (search_len > 1) ? $clog2(search_len) : 1;
  endfunction

  function automatic int unsigned len_w(input int unsigned look_len);
    return (look_len > 1) ? $clog2(look_len) : 1;
  endfunction

endpackage

// File: rtl/lz77_stream_encoder_if.sv
// Char-in / token-out handshake bundle of the LZ77 stream encoder.
interface lz77_stream_encoder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned LEN_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  match_len;
  logic [DATA_W-1:0] char_nxt;
  logic              out_last;
  logic              finish;

  // Char source and token sink side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, offset, match_len, char_nxt, out_last, finish
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, offset, match_len, char_nxt, out_last, finish
  );
endinterface

// File: rtl/lz77_match_len.sv
// Run length of one search candidate against the look-ahead (leading equal chars).
module lz77_match_len import lz77_pkg::*; #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOOK_LEN = 8,
  parameter int unsigned LEN_W    = len_w(LOOK_LEN)
) (
  input  logic [LOOK_LEN-2:0][DATA_W-1:0] cand_i,
  input  logic [LOOK_LEN-2:0][DATA_W-1:0] look_i,
  input  logic [LOOK_LEN-2:0]             look_en_i,
  input  logic                            cand_vld_i,
  output logic [LEN_W-1:0]                len_o
);

  logic [LOOK_LEN-2:0] hit;
  logic                run;

  always_comb begin
    for (int j = 0; j < LOOK_LEN - 1; j++) begin
      hit[j] = cand_vld_i && look_en_i[j] && (cand_i[j] == look_i[j]);
    end
  end

  always_comb begin
    run   = 1'b1;
    len_o = '0;
    for (int j = 0; j < LOOK_LEN - 1; j++) begin
      run = run & hit[j];
      if (run) len_o = LEN_W'(j + 1);
    end
  end

endmodule

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: chars in over valid/ready, (offset, match_len, char_nxt) tokens out.
// Define LZ77_NEAREST_MATCH_EN to resolve equal-length matches to the most recent candidate.
module lz77_stream_encoder import lz77_pkg::*; #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEARCH_LEN = 9,
  parameter int unsigned LOOK_LEN   = 8
) (
  input logic                 clk,
  input logic                 reset,
  lz77_stream_encoder_if.slave bus
);

  localparam int unsigned OFF_W   = off_w(SEARCH_LEN);
  localparam int unsigned LEN_W   = len_w(LOOK_LEN);
  localparam int unsigned CNT_W   = $clog2(LOOK_LEN + 1);
  localparam int unsigned WIN_LEN = SEARCH_LEN + LOOK_LEN - 2;

`ifdef LZ77_NEAREST_MATCH_EN
  localparam bit PreferNearest = 1'b1;
`else
  localparam bit PreferNearest = 1'b0;
`endif

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  match_len;
    logic [DATA_W-1:0] char_nxt;
    logic              last;
  } token_t;

  state_e                           state_q, state_d;
  logic [SEARCH_LEN-1:0][DATA_W-1:0] search_q, search_d;
  logic [SEARCH_LEN-1:0]            search_vld_q, search_vld_d;
  logic [LOOK_LEN-1:0][DATA_W-1:0]  look_q, look_d;
  logic [LOOK_LEN-1:0]              look_vld_q, look_vld_d;
  logic                             last_seen_q, last_seen_d;
  logic [CNT_W-1:0]                 shift_cnt_q, shift_cnt_d;
  token_t                           tok_q, tok_d;

  logic                             in_ready, accept, do_shift, do_clear, last_now;
  logic [CNT_W-1:0]                 look_cnt, look_cnt_nxt, wr_idx;
  logic [WIN_LEN-1:0][DATA_W-1:0]   win;
  logic [SEARCH_LEN-1:0][LEN_W-1:0] cand_len;
  logic [LEN_W-1:0]                 best_len;
  logic [OFF_W-1:0]                 best_off;

  always_comb begin
    look_cnt = '0;
    for (int j = 0; j < LOOK_LEN; j++) look_cnt = look_cnt + CNT_W'(look_vld_q[j]);
  end

  // Oldest search char sits lowest so candidate at offset o reads upward and may run into look.
  always_comb begin
    for (int i = 0; i < SEARCH_LEN; i++) win[SEARCH_LEN-1-i] = search_q[i];
    for (int j = 0; j < LOOK_LEN - 2; j++) win[SEARCH_LEN+j] = look_q[j];
  end

  for (genvar o = 0; o < SEARCH_LEN; o++) begin : g_cand
    lz77_match_len #(
      .DATA_W   (DATA_W),
      .LOOK_LEN (LOOK_LEN)
    ) u_match_len (
      .cand_i     (win[SEARCH_LEN-1-o +: LOOK_LEN-1]),
      .look_i     (look_q[LOOK_LEN-2:0]),
      .look_en_i  (look_vld_q[LOOK_LEN-1:1]),
      .cand_vld_i (search_vld_q[o]),
      .len_o      (cand_len[o])
    );
  end

  always_comb begin
    best_len = '0;
    best_off = '0;
    for (int o = 0; o < SEARCH_LEN; o++) begin
      if ((cand_len[o] > best_len) ||
          (!PreferNearest && (cand_len[o] != '0) && (cand_len[o] == best_len))) begin
        best_len = cand_len[o];
        best_off = OFF_W'(o);
      end
    end
  end

  // Control: handshake, shift sequencing and state transitions.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    do_clear    = 1'b0;
    do_shift    = (state_q == StShift);
    in_ready    = !last_seen_q &&
                  (((state_q == StFill) && (look_cnt != CNT_W'(LOOK_LEN))) || do_shift);
    accept       = bus.in_valid && in_ready;
    look_cnt_nxt = look_cnt - CNT_W'(do_shift) + CNT_W'(accept);
    last_now     = last_seen_q || (accept && bus.in_last);

    unique case (state_q)
      StFill: begin
        if (accept && (bus.in_last || (look_cnt_nxt == CNT_W'(LOOK_LEN)))) state_d = StMatch;
      end
      StMatch: state_d = StEmit;
      StEmit: begin
        if (bus.out_ready) begin
          if (tok_q.last) begin
            state_d = StDone;
          end else begin
            state_d     = StShift;
            shift_cnt_d = CNT_W'(tok_q.match_len) + CNT_W'(1);
          end
        end
      end
      StShift: begin
        shift_cnt_d = shift_cnt_q - CNT_W'(1);
        if (shift_cnt_q == CNT_W'(1)) begin
          if ((look_cnt_nxt == CNT_W'(LOOK_LEN)) || (last_now && (look_cnt_nxt != '0))) begin
            state_d = StMatch;
          end else begin
            state_d = StFill;
          end
        end
      end
      StDone: begin
        if (bus.in_valid) begin
          do_clear = 1'b1;
          state_d  = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Window datapath: shift, tail write, and clear on a new stream.
  always_comb begin
    search_d     = search_q;
    search_vld_d = search_vld_q;
    look_d       = look_q;
    look_vld_d   = look_vld_q;
    last_seen_d  = do_clear ? 1'b0 : last_now;
    wr_idx       = do_shift ? (look_cnt - CNT_W'(1)) : look_cnt;

    if (do_clear) begin
      search_d     = '0;
      search_vld_d = '0;
      look_d       = '0;
      look_vld_d   = '0;
    end

    if (do_shift) begin
      search_d[0]     = look_q[0];
      search_vld_d[0] = look_vld_q[0];
      for (int i = 1; i < SEARCH_LEN; i++) begin
        search_d[i]     = search_q[i-1];
        search_vld_d[i] = search_vld_q[i-1];
      end
      for (int j = 0; j < LOOK_LEN - 1; j++) begin
        look_d[j]     = look_q[j+1];
        look_vld_d[j] = look_vld_q[j+1];
      end
      look_d[LOOK_LEN-1]     = '0;
      look_vld_d[LOOK_LEN-1] = 1'b0;
    end

    if (accept) begin
      for (int j = 0; j < LOOK_LEN; j++) begin
        if (CNT_W'(j) == wr_idx) begin
          look_d[j]     = bus.in_data;
          look_vld_d[j] = 1'b1;
        end
      end
    end
  end

  // Token is captured at the end of MATCH; char_nxt is the last char when it closes the stream.
  always_comb begin
    tok_d = tok_q;
    if (state_q == StMatch) begin
      tok_d.offset    = best_off;
      tok_d.match_len = best_len;
      tok_d.char_nxt  = look_q[best_len];
      tok_d.last      = last_seen_q && ((CNT_W'(best_len) + CNT_W'(1)) == look_cnt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StFill;
      search_q     <= '0;
      search_vld_q <= '0;
      look_q       <= '0;
      look_vld_q   <= '0;
      last_seen_q  <= 1'b0;
      shift_cnt_q  <= '0;
      tok_q        <= '0;
    end else begin
      state_q      <= state_d;
      search_q     <= search_d;
      search_vld_q <= search_vld_d;
      look_q       <= look_d;
      look_vld_q   <= look_vld_d;
      last_seen_q  <= last_seen_d;
      shift_cnt_q  <= shift_cnt_d;
      tok_q        <= tok_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StEmit);
  assign bus.offset    = tok_q.offset;
  assign bus.match_len = tok_q.match_len;
  assign bus.char_nxt  = tok_q.char_nxt;
  assign bus.out_last  = tok_q.last;
  assign bus.finish    = (state_q == StDone);

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Scoreboard bench for lz77_stream_encoder: directed streams, expected tokens queued, monitor compares.
module tb_lz77_stream_encoder;
  import lz77_pkg::*;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SEARCH_LEN = 9;
  localparam int unsigned LOOK_LEN   = 8;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned LEN_W      = 3;

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] ch;
    logic              last;
  } tok_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  lz77_stream_encoder_if #(.DATA_W(DATA_W), .OFF_W(OFF_W), .LEN_W(LEN_W)) bus ();

  lz77_stream_encoder #(
    .DATA_W     (DATA_W),
    .SEARCH_LEN (SEARCH_LEN),
    .LOOK_LEN   (LOOK_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  tok_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   stall_cfg = 0;
  int   hs_cnt    = 0;

  always @(posedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end

  function automatic tok_t mk(input int off, input int len, input byte ch, input bit last);
    return {OFF_W'(off), LEN_W'(len), ch, last};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_tok(input string name, input tok_t act, input tok_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got (%0d,%0d,%c,last=%0b) expected (%0d,%0d,%c,last=%0b)", name,
                  act.offset, act.len, act.ch, act.last, exp.offset, exp.len, exp.ch, exp.last);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_offset", bus.offset, 0);
    check("rst_match_len", bus.match_len, 0);
    check("rst_char_nxt", bus.char_nxt, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_finish", bus.finish, 0);
  endtask

  // Monitor: holds out_ready low for stall_cfg cycles per token, checks stability, then pops.
  initial begin : monitor
    tok_t cur;
    tok_t cap;
    bit   held;
    int   stall;
    held = 1'b0;
    stall = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
        bus.out_ready = 1'b1;
      end else if (bus.out_valid) begin
        cur = {bus.offset, bus.match_len, bus.char_nxt, bus.out_last};
        if (!held) begin
          held = 1'b1;
          cap = cur;
          stall = 0;
        end else begin
          check_tok("hold_stable", cur, cap);
        end
        if (stall < stall_cfg) begin
          bus.out_ready = 1'b0;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_token: got (%0d,%0d,%c,last=%0b) expected none",
                     cur.offset, cur.len, cur.ch, cur.last);
          end else begin
            check_tok("token", cur, exp_q.pop_front());
          end
          held = 1'b0;
        end
      end
    end
  end

  task automatic send(input string s, input bit with_last);
    int t;
    @(posedge clk);
    #1;
    for (int i = 0; i < s.len(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      bus.in_last  = with_last && (i == s.len() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        t++;
        if (t > 300) break;
      end
      if (t > 300) begin
        n_checks++;
        $display("FAIL send_timeout: got no in_ready for char %0d of \"%s\" required accept", i, s);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int t;
    t = 0;
    while (!bus.finish && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, bus.finish, 1);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    int t;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;

    // Repeated pattern: long overlapping back-reference closes the stream.
    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 0, "b", 0));
    exp_q.push_back(mk(0, 0, "c", 0));
    exp_q.push_back(mk(2, 6, "d", 1));
    send("abcabcabcd", 1);
    wait_finish("abc_finish");

    // Equal-length candidates exercise the tie-break.
    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 0, "X", 0));
    exp_q.push_back(mk(1, 1, "Y", 0));
`ifdef LZ77_NEAREST_MATCH_EN
    exp_q.push_back(mk(1, 1, "Z", 1));
`else
    exp_q.push_back(mk(3, 1, "Z", 1));
`endif
    send("aXaYaZ", 1);
    wait_finish("tie_finish");

    // Run of one char: overlap into look-ahead, capped at LOOK_LEN-1, lone final literal.
    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 7, "a", 0));
    exp_q.push_back(mk(0, 0, "a", 1));
    send("aaaaaaaaaa", 1);
    wait_finish("run_finish");

    // Backpressure: every token stalled five cycles.
    stall_cfg = 5;
    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 0, "b", 0));
    exp_q.push_back(mk(0, 0, "c", 0));
    exp_q.push_back(mk(2, 6, "d", 1));
    send("abcabcabcd", 1);
    wait_finish("stall_finish");
    stall_cfg = 0;

    // Reset asserted while shifting after the second token.
    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 0, "b", 0));
    base = hs_cnt;
    send("abcabcabc", 0);
    t = 0;
    while (hs_cnt < base + 2 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("reset_point_reached", hs_cnt - base, 2);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    exp_q.push_back(mk(0, 0, "a", 0));
    exp_q.push_back(mk(0, 0, "b", 1));
    send("ab", 1);
    wait_finish("post_reset_finish");

    // Back-to-back stream must not match into the previous stream's history.
    exp_q.push_back(mk(0, 0, "b", 1));
    send("b", 1);
    check("finish_cleared", bus.finish, 0);
    wait_finish("b2b_finish");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
